// File: rtl/word_packer.sv
// Serial-to-parallel word packer. Collects N_WORDS signed words into one packed frame.
// A fill buffer keeps loading while the previous frame waits in the output register.

module word_packer_slot #(
  parameter int NB_DATA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [NB_DATA-1:0] d,
  output logic [NB_DATA-1:0] q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module word_packer #(
  parameter int N_WORDS = 16,
  parameter int NB_DATA = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NB_DATA-1:0]           i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_flush,
  output logic [N_WORDS*NB_DATA-1:0]   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(N_WORDS)-1:0]   o_count
);
  localparam int CW = $clog2(N_WORDS);

  logic [N_WORDS-2:0][NB_DATA-1:0] fill_q;
  logic [N_WORDS-2:0]              slot_we;
  logic                            accept, take, last;

  assign last    = (o_count == CW'(N_WORDS-1));
  // Only the final word can collide with an untaken output frame.
  assign o_ready = !i_flush && !(last && o_valid && !i_ready);
  assign accept  = i_valid && o_ready;
  assign take    = o_valid && i_ready;

  // The last word bypasses the fill buffer straight into the output register.
  for (genvar k = 0; k < N_WORDS-1; k++) begin : g_slot
    assign slot_we[k] = accept && !last && (o_count == CW'(k));
    word_packer_slot #(.NB_DATA(NB_DATA)) u_slot (
      .clock (clock),
      .reset (reset),
      .we    (slot_we[k]),
      .d     (i_data),
      .q     (fill_q[k])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 o_count <= '0;
    else if (i_flush)          o_count <= '0;
    else if (accept && last)   o_count <= '0;
    else if (accept)           o_count <= o_count + CW'(1);
  end

  // Completion takes priority over take so a coincident take/complete has no bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (accept && last) begin
      o_data  <= {i_data, fill_q};
      o_valid <= 1'b1;
    end else if (take) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Serial-to-parallel loader that feeds the packed dot-product multiplier.
- Accepts one signed NB_DATA-bit word per handshake and collects N_WORDS of them into a frame.
- Presents the frame on the packed bus layout the multiplier consumes, with a valid/ready handshake on both sides.
- Double-buffered: a fill buffer keeps loading while a completed frame waits for downstream, so back-to-back frames run at one word per clock.

Parameters:
- N_WORDS, 16, words per frame; integer >= 2.
- NB_DATA, 8, bits per word.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  NB_DATA  input word.
- i_valid  input  1  i_data is valid this cycle.
- o_ready  output  1  packer accepts i_data this cycle (combinational).
- i_flush  input  1  synchronous discard of the partial frame.
- o_data  output  N_WORDS*NB_DATA  packed frame; word k at bits [(k+1)*NB_DATA-1 -: NB_DATA].
- o_valid  output  1  o_data holds a complete frame.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_count  output  $clog2(N_WORDS)  number of words held in the fill buffer.

Behaviour:
- Reset (asynchronous, active-high), any time including mid-frame:
  - o_data = 0, o_valid = 0, o_count = 0, fill buffer cleared.
  - Any partial frame is lost.
- Definitions:
  - accept = i_valid && o_ready.
  - take = o_valid && i_ready.
  - last = (o_count == N_WORDS-1).
- o_ready:
  - o_ready = !i_flush && !(last && o_valid && !i_ready).
  - Throttles only when the final word of a frame would overwrite an output frame not yet taken.
  - Does not depend on i_valid.
- Ordering: the first accepted word of a frame is word 0, in the LSBs. The N_WORDS-th accepted word is word N_WORDS-1, in the MSBs.
- Fill stage:
  - accept && !last: buffer[o_count] <= i_data; o_count increments.
  - accept && last: o_data <= {i_data, buffer words N_WORDS-2..0}; o_valid <= 1; o_count <= 0.
- Output stage:
  - take && no completion in the same cycle: o_valid <= 0; o_data keeps its value.
  - take && completion in the same cycle: o_valid stays 1 and o_data loads the new frame (no bubble).
  - o_valid && !i_ready: o_data and o_valid hold stable. No change on o_data while o_valid=1 unless take.
- Latency: o_valid rises on the clock edge that accepts the last word, so it is visible the cycle after that word is presented.
- Throughput: one frame per N_WORDS cycles with i_valid and i_ready held high.
- Flush:
  - i_flush=1: o_count <= 0 and the buffer contents are discarded.
  - o_ready is low, so a simultaneous i_valid word is dropped.
  - o_valid and o_data are unaffected; a take in the same cycle still completes.
- State summary:
  - Fill states: COUNT = 0..N_WORDS-1.
  - Output states: EMPTY (o_valid=0) and HOLD (o_valid=1).
  - HOLD->EMPTY on take without completion.
  - EMPTY->HOLD on completion.
  - HOLD->HOLD on take with completion, or on no take.
- Arithmetic: none. Words are stored bit-exact; signedness is interpreted only downstream.

Test Plan:
- Basic frame:
  - Stimulus: after reset, i_ready=1, feed 0x01..0x10 on consecutive cycles.
  - Response: o_valid pulses 1 cycle with o_data = 0x100F0E0D0C0B0A090807060504030201; o_count returns to 0.
- Back-pressure:
  - Stimulus: i_ready=0, feed frame A (0x01..0x10) then frame B (0x11..0x20).
  - Response: o_data stays frame A. o_ready drops while o_count=15 and o_valid=1. Word 0x20 is not accepted until i_ready=1.
  - Then, on the cycle the held 0x20 is accepted, the take of frame A and the completion of frame B coincide. o_valid stays 1 with no bubble and o_data = 0x201F...11.
- Back-to-back:
  - Stimulus: i_valid=i_ready=1, 48 words.
  - Response: three o_valid pulses exactly 16 cycles apart; o_ready never drops.
- Flush mid-frame:
  - Stimulus: feed 0xAA x5, assert i_flush for 1 cycle with i_valid=1, data 0xBB; then feed 0x01..0x10.
  - Response: 0xBB is dropped; the next frame equals the basic frame value.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between clock edges) with o_valid=1 and o_count=7.
  - Response: o_valid, o_data and o_count go to 0 immediately, before the next clock edge. The next 16 words form a clean frame.
- Idle gaps:
  - Stimulus: i_valid toggling 1/0 each cycle, 16 words.
  - Response: o_valid rises only after the 16th word; no spurious o_valid.
